csr_mmio_port: RTL and testbench

Front-end bridge between the load/store unit and the control-register block. Takes one memory-mapped load or store at a time, decodes it against a fixed 512-byte CSR window, and converts it into the control-register block's registered active-low strobe interface. Stalls stores while that block reports busy, for example during an SPI shift. Returns load data as a tagged writeback.

---
 rtl/csr_mmio_port_if.sv | 44 ++++
 rtl/csr_mmio_port.sv | 170 +++++++++++++++++
 tb/tb_csr_mmio_port.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_mmio_port_if.sv
// csr_mmio_port_if: the load/store request and result bundle together with
// the control-register strobe bus handled by csr_mmio_port.
// slave  = the port itself; master = whoever drives requests, read data and busy.
interface csr_mmio_port_if #(
  parameter int TAG_W = 6
);
  logic             IN_valid;
  logic             OUT_ready;
  logic             IN_isStore;
  logic [31:0]      IN_addr;
  logic [31:0]      IN_data;
  logic [3:0]       IN_wmask;
  logic [TAG_W-1:0] IN_tag;
  logic             IN_flush;
  logic             OUT_we;
  logic [3:0]       OUT_wm;
  logic [6:0]       OUT_writeAddr;
  logic [31:0]      OUT_wdata;
  logic             OUT_re;
  logic [6:0]       OUT_readAddr;
  logic [31:0]      IN_rdata;
  logic             IN_IO_busy;
  logic             OUT_resValid;
  logic [TAG_W-1:0] OUT_resTag;
  logic [31:0]      OUT_resData;
  logic             OUT_resFault;
  logic             OUT_stAck;

  modport slave (
    input  IN_valid, IN_isStore, IN_addr, IN_data, IN_wmask, IN_tag, IN_flush,
    input  IN_rdata, IN_IO_busy,
    output OUT_ready, OUT_we, OUT_wm, OUT_writeAddr, OUT_wdata, OUT_re,
    output OUT_readAddr, OUT_resValid, OUT_resTag, OUT_resData, OUT_resFault,
    output OUT_stAck
  );

  modport master (
    output IN_valid, IN_isStore, IN_addr, IN_data, IN_wmask, IN_tag, IN_flush,
    output IN_rdata, IN_IO_busy,
    input  OUT_ready, OUT_we, OUT_wm, OUT_writeAddr, OUT_wdata, OUT_re,
    input  OUT_readAddr, OUT_resValid, OUT_resTag, OUT_resData, OUT_resFault,
    input  OUT_stAck
  );
endinterface

// File: rtl/csr_mmio_port.sv
// csr_mmio_port: bridges one MMIO load/store at a time onto the control
// register block's registered active-low strobe bus. Stores wait out IN_IO_busy;
// loads return a tagged result four cycles after accept.
// Optional feature macro CSR_MMIO_FAULT_EN: when defined, accesses outside the
// 512-byte window at BASE_ADDR fault instead of aliasing onto IN_addr[8:2].
module csr_mmio_port #(
  parameter logic [31:0] BASE_ADDR = 32'hFF00_0000,
  parameter int          TAG_W     = 6
) (
  input logic            clk,
  input logic            rst,
  csr_mmio_port_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_WAIT  = 3'd1,
    WR_ISSUE = 3'd2,
    RD_ISSUE = 3'd3,
    RD_W1    = 3'd4,
    RD_W2    = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t           state_r;
  logic             we_r;
  logic             re_r;
  logic             st_ack_r;
  logic             res_valid_r;
  logic             res_fault_r;
  logic             kill_r;
  logic             fault_r;
  logic [3:0]       wm_r;
  logic [6:0]       waddr_r;
  logic [6:0]       raddr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      res_data_r;
  logic [TAG_W-1:0] tag_r;
  logic [TAG_W-1:0] res_tag_r;

  logic             ready_s;
  logic             window_hit_s;
  logic             in_window_s;
  logic [6:0]       reg_addr_s;
  logic             unused_s;

  assign reg_addr_s   = bus.IN_addr[8:2];
  assign window_hit_s = (bus.IN_addr[31:9] == BASE_ADDR[31:9]);
  // Held low during reset so nothing can be accepted while rst is asserted.
  assign ready_s      = rst && (state_r == IDLE) && !bus.IN_flush;

`ifdef CSR_MMIO_FAULT_EN
  assign in_window_s      = window_hit_s;
  assign bus.OUT_resFault = res_fault_r;
  assign unused_s         = ^bus.IN_addr[1:0];
`else
  // Without fault reporting every address aliases into the window.
  assign in_window_s      = 1'b1;
  assign bus.OUT_resFault = 1'b0;
  assign unused_s         = ^{bus.IN_addr[1:0], window_hit_s, res_fault_r};
`endif

  assign bus.OUT_ready     = ready_s;
  assign bus.OUT_we        = we_r;
  assign bus.OUT_wm        = wm_r;
  assign bus.OUT_writeAddr = waddr_r;
  assign bus.OUT_wdata     = wdata_r;
  assign bus.OUT_re        = re_r;
  assign bus.OUT_readAddr  = raddr_r;
  assign bus.OUT_resValid  = res_valid_r;
  assign bus.OUT_resTag    = res_tag_r;
  assign bus.OUT_resData   = res_data_r;
  assign bus.OUT_stAck     = st_ack_r;

  // Request FSM; every strobe/result output is set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b1;
      re_r        <= 1'b1;
      st_ack_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_fault_r <= 1'b0;
      kill_r      <= 1'b0;
      fault_r     <= 1'b0;
      wm_r        <= 4'd0;
      waddr_r     <= 7'd0;
      raddr_r     <= 7'd0;
      wdata_r     <= 32'd0;
      res_data_r  <= 32'd0;
      tag_r       <= {TAG_W{1'b0}};
      res_tag_r   <= {TAG_W{1'b0}};
    end else begin
      // Pulsed outputs fall back to idle unless a transition below re-asserts them.
      we_r        <= 1'b1;
      re_r        <= 1'b1;
      st_ack_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_fault_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.IN_valid && ready_s) begin
            if (bus.IN_isStore) begin
              waddr_r <= reg_addr_s;
              wdata_r <= bus.IN_data;
              wm_r    <= bus.IN_wmask;
              if (in_window_s) begin
                state_r <= WR_WAIT;
              end else begin
                // Dropped store: acknowledge with fault, never strobe.
                state_r     <= WR_ISSUE;
                st_ack_r    <= 1'b1;
                res_fault_r <= 1'b1;
              end
            end else begin
              raddr_r <= reg_addr_s;
              tag_r   <= bus.IN_tag;
              kill_r  <= 1'b0;
              fault_r <= !in_window_s;
              if (in_window_s) begin
                state_r <= RD_ISSUE;
                re_r    <= 1'b0;
              end else begin
                // Faulting load skips the strobe and waits only in RD_W2.
                state_r <= RD_W2;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WR_WAIT: begin
          if (!bus.IN_IO_busy) begin
            state_r  <= WR_ISSUE;
            we_r     <= (wm_r == 4'd0);
            st_ack_r <= 1'b1;
          end else begin
            state_r <= WR_WAIT;
          end
        end
        WR_ISSUE: begin
          state_r <= IDLE;
        end
        RD_ISSUE: begin
          kill_r  <= kill_r | bus.IN_flush;
          state_r <= RD_W1;
        end
        RD_W1: begin
          kill_r  <= kill_r | bus.IN_flush;
          state_r <= RD_W2;
        end
        RD_W2: begin
          kill_r      <= kill_r | bus.IN_flush;
          state_r     <= RESP;
          res_valid_r <= !(kill_r | bus.IN_flush);
          res_fault_r <= fault_r & !(kill_r | bus.IN_flush);
          res_tag_r   <= tag_r;
          res_data_r  <= fault_r ? 32'd0 : bus.IN_rdata;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_mmio_port.sv
// tb_csr_mmio_port: random load/store traffic against a period-indexed reference
// model; expected strobes, acks and results are queued and checked by a monitor.
module tb_csr_mmio_port;
  localparam int          TAG_W    = 6;
  localparam logic [31:0] BASE     = 32'hFF00_0000;
  localparam int          NPER     = 4096;
  localparam int          RAND_END = 2200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_mmio_port_if #(.TAG_W(TAG_W)) bus ();

  csr_mmio_port #(.BASE_ADDR(BASE), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Period n spans posedge n .. posedge n+1.
  int per = 0;
  always @(posedge clk) per <= per + 1;

  bit          busy_arr  [NPER];
  bit          flush_arr [NPER];
  logic [31:0] rdata_arr [NPER];

  typedef struct { int per; logic [6:0] addr; } rd_exp_t;
  typedef struct { int per; logic [6:0] addr; logic [3:0] wm; logic [31:0] data; } wr_exp_t;
  typedef struct { int per; logic fault; } ack_exp_t;
  typedef struct { int per; logic [TAG_W-1:0] tag; logic [31:0] data; logic fault; } res_exp_t;

  rd_exp_t  rd_q [$];
  wr_exp_t  wr_q [$];
  ack_exp_t ack_q[$];
  res_exp_t res_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (period %0d): got 0x%0h, expected 0x%0h", name, per, act, exp);
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    chk("rst_we",        64'(bus.OUT_we),        64'd1);
    chk("rst_re",        64'(bus.OUT_re),        64'd1);
    chk("rst_ready",     64'(bus.OUT_ready),     64'(exp_ready));
    chk("rst_resValid",  64'(bus.OUT_resValid),  64'd0);
    chk("rst_stAck",     64'(bus.OUT_stAck),     64'd0);
    chk("rst_resFault",  64'(bus.OUT_resFault),  64'd0);
    chk("rst_wm",        64'(bus.OUT_wm),        64'd0);
    chk("rst_writeAddr", 64'(bus.OUT_writeAddr), 64'd0);
    chk("rst_wdata",     64'(bus.OUT_wdata),     64'd0);
    chk("rst_readAddr",  64'(bus.OUT_readAddr),  64'd0);
    chk("rst_resTag",    64'(bus.OUT_resTag),    64'd0);
    chk("rst_resData",   64'(bus.OUT_resData),   64'd0);
  endtask

  // Environment: busy, flush and read data replay the pre-rolled per-period tables.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (per < NPER) begin
        bus.IN_IO_busy = busy_arr[per];
        bus.IN_flush   = flush_arr[per];
        bus.IN_rdata   = rdata_arr[per];
      end
    end
  end

  rd_exp_t  rd_e;
  wr_exp_t  wr_e;
  ack_exp_t ack_e;
  res_exp_t res_e;

  // Monitor: pops one expectation per observed DUT event and compares it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_overlap", 64'(!bus.OUT_we && !bus.OUT_re), 64'd0);
      if (!bus.OUT_re) begin
        chk("re_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          rd_e = rd_q.pop_front();
          chk("re_period", 64'(per), 64'(rd_e.per));
          chk("re_addr",   64'(bus.OUT_readAddr), 64'(rd_e.addr));
        end
      end
      if (!bus.OUT_we) begin
        chk("we_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          wr_e = wr_q.pop_front();
          chk("we_period", 64'(per), 64'(wr_e.per));
          chk("we_addr",   64'(bus.OUT_writeAddr), 64'(wr_e.addr));
          chk("we_wm",     64'(bus.OUT_wm), 64'(wr_e.wm));
          chk("we_data",   64'(bus.OUT_wdata), 64'(wr_e.data));
        end
      end
      if (bus.OUT_stAck) begin
        chk("ack_expected", 64'(ack_q.size() != 0), 64'd1);
        if (ack_q.size() != 0) begin
          ack_e = ack_q.pop_front();
          chk("ack_period", 64'(per), 64'(ack_e.per));
          chk("ack_fault",  64'(bus.OUT_resFault), 64'(ack_e.fault));
        end
      end
      if (bus.OUT_resValid) begin
        chk("res_expected", 64'(res_q.size() != 0), 64'd1);
        if (res_q.size() != 0) begin
          res_e = res_q.pop_front();
          chk("res_period", 64'(per), 64'(res_e.per));
          chk("res_tag",    64'(bus.OUT_resTag), 64'(res_e.tag));
          chk("res_data",   64'(bus.OUT_resData), 64'(res_e.data));
          chk("res_fault",  64'(bus.OUT_resFault), 64'(res_e.fault));
        end
      end
      if (!bus.OUT_resValid && !bus.OUT_stAck) begin
        chk("fault_idle", 64'(bus.OUT_resFault), 64'd0);
      end
    end
  end

  logic             req_store;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic [3:0]       req_wm;
  logic [TAG_W-1:0] req_tag;
  bit               have_req;
  int               free_at;
  int               acc_per;

  // Reference model: derive every consequence of a request accepted in period n.
  task automatic model_accept(input int n);
    logic       inwin;
    logic       killed;
    logic [6:0] ra;
    int         m;
    inwin = 1'b1;
`ifdef CSR_MMIO_FAULT_EN
    inwin = ((req_addr / 32'd512) == (BASE / 32'd512));
`endif
    ra = 7'((req_addr % 32'd512) / 32'd4);
    if (req_store) begin
      if (!inwin) begin
        ack_q.push_back('{n + 1, 1'b1});
        free_at = n + 2;
      end else begin
        m = n + 1;
        while (busy_arr[m]) m++;
        if (req_wm != 4'd0) wr_q.push_back('{m + 1, ra, req_wm, req_data});
        ack_q.push_back('{m + 1, 1'b0});
        free_at = m + 2;
      end
    end else begin
      if (!inwin) begin
        killed = flush_arr[n + 1];
        if (!killed) res_q.push_back('{n + 2, req_tag, 32'd0, 1'b1});
        free_at = n + 3;
      end else begin
        rd_q.push_back('{n + 1, ra});
        killed = flush_arr[n + 1] | flush_arr[n + 2] | flush_arr[n + 3];
        if (!killed) res_q.push_back('{n + 4, req_tag, rdata_arr[n + 3], 1'b0});
        free_at = n + 5;
      end
    end
  endtask

  task automatic gen_request();
    req_store = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) req_addr = $urandom() & 32'hFFFF_FFFC;
    else req_addr = (BASE & 32'hFFFF_FE00) | (32'($urandom_range(0, 127)) << 2);
    req_data = $urandom();
    req_wm   = 4'($urandom_range(0, 15));
    req_tag  = TAG_W'($urandom());
  endtask

  task automatic drive_request();
    bus.IN_valid   = have_req;
    bus.IN_isStore = req_store;
    bus.IN_addr    = req_addr;
    bus.IN_data    = req_data;
    bus.IN_wmask   = req_wm;
    bus.IN_tag     = req_tag;
  endtask

  // Stimulus: random traffic, drain, then reset in the middle of a load.
  initial begin
    for (int i = 0; i < NPER; i++) begin
      busy_arr[i]  = (i < RAND_END) ? ($urandom_range(0, 99) < 35) : 1'b0;
      flush_arr[i] = (i < RAND_END) ? ($urandom_range(0, 99) < 8)  : 1'b0;
      rdata_arr[i] = $urandom();
    end
    rst            = 1'b0;
    have_req       = 1'b0;
    req_store      = 1'b0;
    req_addr       = 32'd0;
    req_data       = 32'd0;
    req_wm         = 4'd0;
    req_tag        = '0;
    bus.IN_flush   = 1'b0;
    bus.IN_IO_busy = 1'b0;
    bus.IN_rdata   = 32'd0;
    drive_request();
    free_at = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    while (per < RAND_END) begin
      if (!have_req && $urandom_range(0, 3) != 0) begin
        gen_request();
        have_req = 1'b1;
      end
      drive_request();
      @(negedge clk);
      chk("ready", 64'(bus.OUT_ready), 64'((per >= free_at) && !flush_arr[per]));
      if (have_req && bus.OUT_ready) begin
        model_accept(per);
        have_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    have_req = 1'b0;
    drive_request();

    for (int i = 0; i < 200 && per <= free_at + 2; i++) @(posedge clk);
    #1;
    chk("drain_done", 64'(per > free_at + 2), 64'd1);
    chk("rd_q_empty",  64'(rd_q.size()),  64'd0);
    chk("wr_q_empty",  64'(wr_q.size()),  64'd0);
    chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);

    // Load at window word 3, tag 5; reset lands while it sits in RD_W1.
    req_store = 1'b0;
    req_addr  = BASE + 32'd12;
    req_tag   = TAG_W'(5);
    have_req  = 1'b1;
    drive_request();
    @(negedge clk);
    acc_per = per;
    chk("rst_test_ready", 64'(bus.OUT_ready), 64'd1);
    if (bus.OUT_ready) rd_q.push_back('{acc_per + 1, 7'd3});
    @(posedge clk);
    #1;
    have_req = 1'b0;
    drive_request();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1'b1);
    repeat (8) @(negedge clk);
    chk("rst_rd_q_empty",  64'(rd_q.size()),  64'd0);
    chk("rst_res_q_empty", 64'(res_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the run is far shorter than this bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
